// File: rtl/instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : instr_enc
// Purpose  : Two-stage valid/ready RV32I instruction encoder. Packs symbolic
//            requests (kind, rd, rs1, rs2, imm) into 32-bit instruction words
//            and flags requests whose immediate does not fit the format.
// Revision : 1.0 - initial release
// ============================================================================
module instr_enc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_kind,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Instruction format classes
  localparam logic [2:0] c_FMT_R  = 3'd0;
  localparam logic [2:0] c_FMT_I  = 3'd1;
  localparam logic [2:0] c_FMT_SH = 3'd2;
  localparam logic [2:0] c_FMT_S  = 3'd3;
  localparam logic [2:0] c_FMT_B  = 3'd4;
  localparam logic [2:0] c_FMT_J  = 3'd5;
  localparam logic [2:0] c_FMT_U  = 3'd6;

  localparam logic [6:0]  c_OP_R    = 7'b0110011;
  localparam logic [6:0]  c_OP_IMM  = 7'b0010011;
  localparam logic [6:0]  c_OP_LOAD = 7'b0000011;
  localparam logic [6:0]  c_OP_JALR = 7'b1100111;
  localparam logic [6:0]  c_OP_STORE= 7'b0100011;
  localparam logic [6:0]  c_OP_BR   = 7'b1100011;
  localparam logic [6:0]  c_OP_JAL  = 7'b1101111;
  localparam logic [6:0]  c_OP_LUI  = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC= 7'b0010111;
  localparam logic [6:0]  c_F7_ALT  = 7'b0100000;
  localparam logic [31:0] c_NOP     = 32'h0000_0013;

  logic             r_s1_valid;
  logic [4:0]       r_s1_kind;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [31:0]      r_s1_imm;
  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic [2:0]       w_fmt;
  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic             w_kind_ok;
  logic             w_imm_ok;
  logic [31:0]      w_word;

  // A stage may load when it is empty or its content moves on this cycle
  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_illegal = r_out_illegal;
  assign illegal_cnt = r_illegal_cnt;

  // Map the kind code onto format, opcode and function fields
  always_comb begin
    w_fmt     = c_FMT_R;
    w_opcode  = c_OP_R;
    w_f3      = 3'd0;
    w_f7      = 7'd0;
    w_kind_ok = 1'b1;
    case (r_s1_kind)
      5'd0:  w_f3 = 3'd0;
      5'd1:  begin w_f3 = 3'd0; w_f7 = c_F7_ALT; end
      5'd2:  w_f3 = 3'd6;
      5'd3:  w_f3 = 3'd7;
      5'd4:  w_f3 = 3'd4;
      5'd5:  w_f3 = 3'd1;
      5'd6:  begin w_f3 = 3'd5; w_f7 = c_F7_ALT; end
      5'd7:  w_f3 = 3'd5;
      5'd8:  w_f3 = 3'd2;
      5'd9:  w_f3 = 3'd3;
      5'd10: begin w_fmt = c_FMT_I;  w_opcode = c_OP_LOAD;  w_f3 = 3'd2; end
      5'd11: begin w_fmt = c_FMT_I;  w_opcode = c_OP_IMM;   w_f3 = 3'd0; end
      5'd12: begin w_fmt = c_FMT_I;  w_opcode = c_OP_IMM;   w_f3 = 3'd6; end
      5'd13: begin w_fmt = c_FMT_I;  w_opcode = c_OP_IMM;   w_f3 = 3'd7; end
      5'd14: begin w_fmt = c_FMT_I;  w_opcode = c_OP_IMM;   w_f3 = 3'd4; end
      5'd15: begin w_fmt = c_FMT_SH; w_opcode = c_OP_IMM;   w_f3 = 3'd5; w_f7 = c_F7_ALT; end
      5'd16: begin w_fmt = c_FMT_I;  w_opcode = c_OP_IMM;   w_f3 = 3'd2; end
      5'd17: begin w_fmt = c_FMT_I;  w_opcode = c_OP_IMM;   w_f3 = 3'd3; end
      5'd18: begin w_fmt = c_FMT_SH; w_opcode = c_OP_IMM;   w_f3 = 3'd1; end
      5'd19: begin w_fmt = c_FMT_SH; w_opcode = c_OP_IMM;   w_f3 = 3'd5; end
      5'd20: begin w_fmt = c_FMT_I;  w_opcode = c_OP_JALR;  w_f3 = 3'd0; end
      5'd21: begin w_fmt = c_FMT_S;  w_opcode = c_OP_STORE; w_f3 = 3'd2; end
      5'd22: begin w_fmt = c_FMT_B;  w_opcode = c_OP_BR;    w_f3 = 3'd0; end
      5'd23: begin w_fmt = c_FMT_J;  w_opcode = c_OP_JAL;   end
      5'd24: begin w_fmt = c_FMT_U;  w_opcode = c_OP_LUI;   end
      5'd25: begin w_fmt = c_FMT_U;  w_opcode = c_OP_AUIPC; end
      default: w_kind_ok = 1'b0;
    endcase
  end

  // Pack fields for the selected format and check the immediate range
  always_comb begin
    w_word   = {w_f7, r_s1_rs2, r_s1_rs1, w_f3, r_s1_rd, w_opcode};
    w_imm_ok = 1'b1;
    case (w_fmt)
      c_FMT_I: begin
        w_word   = {r_s1_imm[11:0], r_s1_rs1, w_f3, r_s1_rd, w_opcode};
        w_imm_ok = (r_s1_imm[31:11] == {21{r_s1_imm[11]}});
      end
      c_FMT_SH: begin
        w_word   = {w_f7, r_s1_imm[4:0], r_s1_rs1, w_f3, r_s1_rd, w_opcode};
        w_imm_ok = (r_s1_imm[31:5] == 27'd0);
      end
      c_FMT_S: begin
        w_word   = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, w_f3, r_s1_imm[4:0], w_opcode};
        w_imm_ok = (r_s1_imm[31:11] == {21{r_s1_imm[11]}});
      end
      c_FMT_B: begin
        w_word   = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, w_f3,
                    r_s1_imm[4:1], r_s1_imm[11], w_opcode};
        w_imm_ok = !r_s1_imm[0] && (r_s1_imm[31:12] == {20{r_s1_imm[12]}});
      end
      c_FMT_J: begin
        w_word   = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                    r_s1_rd, w_opcode};
        w_imm_ok = !r_s1_imm[0] && (r_s1_imm[31:20] == {12{r_s1_imm[20]}});
      end
      c_FMT_U: begin
        w_word   = {r_s1_imm[31:12], r_s1_rd, w_opcode};
        w_imm_ok = (r_s1_imm[11:0] == 12'd0);
      end
      default: ;
    endcase
  end

  // Stage 1: capture the accepted request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_kind  <= 5'd0;
      r_s1_rd    <= 5'd0;
      r_s1_rs1   <= 5'd0;
      r_s1_rs2   <= 5'd0;
      r_s1_imm   <= 32'd0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_kind <= in_kind;
        r_s1_rd   <= in_rd;
        r_s1_rs1  <= in_rs1;
        r_s1_rs2  <= in_rs2;
        r_s1_imm  <= in_imm;
      end
    end
  end

  // Stage 2: register the encoded word, substituting a nop when unencodable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'd0;
      r_out_illegal <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_instr   <= (w_kind_ok && w_imm_ok) ? w_word : c_NOP;
        r_out_illegal <= !(w_kind_ok && w_imm_ok);
      end
    end
  end

  // Count illegal words as they are handed to the consumer, saturating
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_illegal_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_illegal && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_enc
// Purpose  : Self-checking bench for instr_enc: directed vectors, random
//            stream against a behavioural scoreboard, stall, reset, saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_enc;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_kind = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_instr;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;
  logic [32:0] exp_q[$];
  logic last_acc = 1'b0;
  bit   sat_mode = 1'b0;

  instr_enc #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {illegal, word} from the ISA rules using integer ranges
  function automatic logic [32:0] model(input int kind, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    int s;
    string fmt;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] w;
    bit ok;
    s  = $signed(imm);
    f7 = 7'd0;
    op = 7'h33;
    fmt = "R";
    case (kind)
      0: f3 = 0;  1: begin f3 = 0; f7 = 7'h20; end
      2: f3 = 6;  3: f3 = 7;  4: f3 = 4;  5: f3 = 1;
      6: begin f3 = 5; f7 = 7'h20; end
      7: f3 = 5;  8: f3 = 2;  9: f3 = 3;
      10: begin fmt = "I"; op = 7'h03; f3 = 2; end
      11: begin fmt = "I"; op = 7'h13; f3 = 0; end
      12: begin fmt = "I"; op = 7'h13; f3 = 6; end
      13: begin fmt = "I"; op = 7'h13; f3 = 7; end
      14: begin fmt = "I"; op = 7'h13; f3 = 4; end
      15: begin fmt = "H"; op = 7'h13; f3 = 5; f7 = 7'h20; end
      16: begin fmt = "I"; op = 7'h13; f3 = 2; end
      17: begin fmt = "I"; op = 7'h13; f3 = 3; end
      18: begin fmt = "H"; op = 7'h13; f3 = 1; end
      19: begin fmt = "H"; op = 7'h13; f3 = 5; end
      20: begin fmt = "I"; op = 7'h67; f3 = 0; end
      21: begin fmt = "S"; op = 7'h23; f3 = 2; end
      22: begin fmt = "B"; op = 7'h63; f3 = 0; end
      23: begin fmt = "J"; op = 7'h6F; f3 = 0; end
      24: begin fmt = "U"; op = 7'h37; f3 = 0; end
      25: begin fmt = "U"; op = 7'h17; f3 = 0; end
      default: begin fmt = "X"; f3 = 0; end
    endcase
    ok = 1'b1;
    w  = 32'd0;
    case (fmt)
      "R": w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      "I": begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      "H": begin
        ok = (imm < 32);
        w  = (f7 << 25) | ((imm % 32) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      "S": begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
      end
      "B": begin
        ok = (s % 2 == 0) && (s >= -4096) && (s <= 4095);
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 1) << 7) | op;
      end
      "J": begin
        ok = (s % 2 == 0) && (s >= -(1 << 20)) && (s < (1 << 20));
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      "U": begin
        ok = (imm % 4096 == 0);
        w  = imm | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  // Scoreboard: compare deliveries in order, then record new accepts
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rstn) begin
      exp_q.delete();
      model_cnt = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_illegal_cnt", illegal_cnt, 0);
    end else begin
      check("illegal_cnt", illegal_cnt, model_cnt);
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_instr", out_instr, e[31:0]);
          check("sb_illegal", out_illegal, e[32]);
          if (e[32] && model_cnt < CNT_MAX) model_cnt++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_kind, in_rd, in_rs1, in_rs2, in_imm));
    end
  end

  task automatic rand_item();
    int m;
    in_kind = sat_mode ? 5'd30 : 5'($urandom_range(0, 31));
    in_rd   = 5'($urandom);
    in_rs1  = 5'($urandom);
    in_rs2  = 5'($urandom);
    m = $urandom_range(0, 3);
    case (m)
      0: in_imm = 32'($signed($urandom_range(0, 8191)) - 4096);
      1: in_imm = 32'($urandom_range(0, 40));
      2: in_imm = $urandom << 12;
      default: in_imm = $urandom;
    endcase
  endtask

  // One cycle of stream driving: a pending request is held until accepted
  task automatic step(input bit want, input bit rdy);
    @(posedge clk); #1;
    out_ready = rdy;
    if (!in_valid || last_acc) begin
      if (want) begin rand_item(); in_valid = 1'b1; end
      else in_valid = 1'b0;
    end
    @(negedge clk);
    last_acc = in_valid && in_ready;
  endtask

  task automatic drain();
    int n = 0;
    while ((in_valid || out_valid || exp_q.size() != 0) && n < 60) begin
      step(0, 1);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic single(input string tag, input logic [4:0] k, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] ew, input logic ei);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_instr"}, out_instr, ew);
    check({tag, "_illegal"}, out_illegal, ei);
    last_acc = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Directed legal encodings
    single("add",   0, 3, 1, 2, 32'd0,          32'h002081B3, 0);
    single("addi",  11, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFF00093, 0);
    single("srai",  15, 4, 4, 0, 32'd3,         32'h40325213, 0);
    single("sw",    21, 0, 1, 2, 32'd8,         32'h0020A423, 0);
    single("beq",   22, 0, 1, 2, 32'hFFFF_FFFC, 32'hFE208EE3, 0);
    single("jal",   23, 1, 0, 0, 32'd2048,      32'h001000EF, 0);
    single("lui",   24, 5, 0, 0, 32'h1234_5000, 32'h123452B7, 0);

    // Unencodable requests
    single("ill_addi", 11, 1, 0, 0, 32'd2048,      32'h13, 1);
    single("ill_beq",  22, 0, 1, 2, 32'd3,         32'h13, 1);
    single("ill_slli", 18, 1, 1, 0, 32'd32,        32'h13, 1);
    single("ill_lui",  24, 5, 0, 0, 32'h1234_5001, 32'h13, 1);
    single("ill_kind", 30, 1, 1, 1, 32'd0,         32'h13, 1);
    @(negedge clk);
    check("illegal_cnt_5", illegal_cnt, 5);

    // Back-to-back stream of eight R-type requests
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i < 8) begin
        rand_item();
        in_kind = 5'($urandom_range(0, 9));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check("b2b_in_ready", in_ready, 1);
      if (i >= 2) check("b2b_out_valid", out_valid, 1);
    end
    last_acc = 1'b0;
    drain();

    // Consumer stall for five cycles with a continuous request stream
    held = '0;
    for (int c = 0; c < 5; c++) begin
      step(1, 0);
      if (c == 2) begin
        check("stall_full_valid", out_valid, 1);
        held = out_instr;
      end
      if (c >= 2) check("stall_in_ready", in_ready, 0);
      if (c >= 3) check("stall_hold", out_instr, held);
    end
    for (int c = 0; c < 6; c++) step(c < 4, 1);
    drain();

    // Random stream with random consumer back-pressure
    for (int c = 0; c < 300; c++) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    drain();

    // Reset with two entries in flight
    @(posedge clk); #1;
    rand_item(); in_kind = 5'd30; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rand_item(); in_kind = 5'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cnt", illegal_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    last_acc = 1'b0;
    single("post_rst", 9, 7, 6, 5, 32'd0, 32'h005333B3, 0);
    drain();

    // Saturate the illegal counter
    sat_mode = 1'b1;
    for (int c = 0; c < 262; c++) step(1, 1);
    drain();
    check("cnt_saturated", illegal_cnt, CNT_MAX);
    for (int c = 0; c < 4; c++) step(1, 1);
    drain();
    check("cnt_sat_hold", illegal_cnt, CNT_MAX);
    sat_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
